// File: rtl/vga_timing_core_if.sv
// Frame-buffer read port: pixel request/address out, pixel data back.
interface vga_timing_core_if #(
  parameter int unsigned CNT_W = 12
);
  logic             req;
  logic [CNT_W-1:0] addr_x;
  logic [CNT_W-1:0] addr_y;
  logic [23:0]      rgb_data;

  modport master (output req, output addr_x, output addr_y, input rgb_data);
  modport slave  (input req, input addr_x, input addr_y, output rgb_data);
endinterface

// File: rtl/vga_timing_core.sv
// Parametrised VGA/HDMI timing generator with pixel-read latency compensation.
module vga_timing_core #(
  parameter int unsigned H_ACT   = 1280,
  parameter int unsigned H_FRONT = 110,
  parameter int unsigned H_SYNC  = 40,
  parameter int unsigned H_BACK  = 220,
  parameter int unsigned V_ACT   = 720,
  parameter int unsigned V_FRONT = 5,
  parameter int unsigned V_SYNC  = 5,
  parameter int unsigned V_BACK  = 20,
  parameter int unsigned HS_POL  = 1,
  parameter int unsigned VS_POL  = 1,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned PIX_FMT = 0,
  parameter int unsigned CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  vga_timing_core_if.master   fb,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic                frame_start,
  output logic                line_start,
  output logic [7:0]          rgb_r,
  output logic [7:0]          rgb_g,
  output logic [7:0]          rgb_b
);

  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int unsigned H_ACT_LO = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_HI = H_ACT_LO + H_ACT;
  localparam int unsigned V_ACT_LO = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_HI = V_ACT_LO + V_ACT;
  // Stage 0 is aligned with req; the last stage drives the display outputs.
  localparam int unsigned DEPTH    = RD_LAT + 2;

  // Marker bit positions within a pipeline stage.
  localparam int unsigned M_HS = 0;
  localparam int unsigned M_VS = 1;
  localparam int unsigned M_DE = 2;
  localparam int unsigned M_FS = 3;
  localparam int unsigned M_LS = 4;
  localparam int unsigned M_W  = 5;

  localparam logic HS_ON  = 1'(HS_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(VS_POL);
  localparam logic VS_OFF = ~VS_ON;
  localparam logic [M_W-1:0] MK_IDLE = {3'b000, VS_OFF, HS_OFF};

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             run_q, run_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] addr_x_q, addr_x_d;
  logic [CNT_W-1:0] addr_y_q, addr_y_d;
  logic [M_W-1:0]   pipe_q [DEPTH];
  logic [M_W-1:0]   pipe_d [DEPTH];
  logic [23:0]      rgb_q, rgb_d;
  logic [23:0]      pix_c;
  logic             live_c, h_act_c, v_act_c, act_c;
  logic             unused_rgb_hi;

  // Raster counters: held at zero while disabled, first counted clock is (0,0).
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    run_d   = en;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (run_q) begin
      if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  // Request stage and marker delay line; en gates req on the very next clock.
  always_comb begin
    live_c   = en & run_q;
    h_act_c  = (h_cnt_q >= CNT_W'(H_ACT_LO)) && (h_cnt_q < CNT_W'(H_ACT_HI));
    v_act_c  = (v_cnt_q >= CNT_W'(V_ACT_LO)) && (v_cnt_q < CNT_W'(V_ACT_HI));
    act_c    = live_c & h_act_c & v_act_c;
    req_d    = act_c;
    addr_x_d = act_c ? h_cnt_q - CNT_W'(H_ACT_LO) : '0;
    addr_y_d = act_c ? v_cnt_q - CNT_W'(V_ACT_LO) : '0;
    pipe_d[0] = MK_IDLE;
    if (live_c) begin
      pipe_d[0][M_HS] = (h_cnt_q < CNT_W'(H_SYNC)) ? HS_ON : HS_OFF;
      pipe_d[0][M_VS] = (v_cnt_q < CNT_W'(V_SYNC)) ? VS_ON : VS_OFF;
      pipe_d[0][M_FS] = (h_cnt_q == '0) && (v_cnt_q == '0);
      pipe_d[0][M_LS] = (h_cnt_q == '0);
    end
    pipe_d[0][M_DE] = act_c;
    for (int i = 1; i < int'(DEPTH); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pixel format expansion; captured only when the returning pixel is valid.
  always_comb begin
    if (PIX_FMT == 1) begin
      pix_c = fb.rgb_data;
    end else begin
      pix_c = {fb.rgb_data[15:11], fb.rgb_data[15:13],
               fb.rgb_data[10:5],  fb.rgb_data[10:9],
               fb.rgb_data[4:0],   fb.rgb_data[4:2]};
    end
    rgb_d = pipe_q[RD_LAT][M_DE] ? pix_c : '0;
  end

  assign unused_rgb_hi = ^fb.rgb_data[23:16];

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      run_q    <= 1'b0;
      req_q    <= 1'b0;
      addr_x_q <= '0;
      addr_y_q <= '0;
      rgb_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= MK_IDLE;
      end
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      run_q    <= run_d;
      req_q    <= req_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      rgb_q    <= rgb_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign fb.req      = req_q;
  assign fb.addr_x   = addr_x_q;
  assign fb.addr_y   = addr_y_q;
  assign h_sync      = pipe_q[DEPTH-1][M_HS];
  assign v_sync      = pipe_q[DEPTH-1][M_VS];
  assign de          = pipe_q[DEPTH-1][M_DE];
  assign frame_start = pipe_q[DEPTH-1][M_FS];
  assign line_start  = pipe_q[DEPTH-1][M_LS];
  assign rgb_r       = rgb_q[23:16];
  assign rgb_g       = rgb_q[15:8];
  assign rgb_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: three small-mode instances (RD_LAT 1/3/0).
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  vga_timing_core_if #(.CNT_W(12)) fb_a ();
  vga_timing_core_if #(.CNT_W(12)) fb_b ();
  vga_timing_core_if #(.CNT_W(12)) fb_c ();

  logic hs_a, vs_a, de_a, fs_a, ls_a;
  logic hs_b, vs_b, de_b, fs_b, ls_b;
  logic hs_c, vs_c, de_c, fs_c, ls_c;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  // A: RGB888, active-high syncs, 1-clock read latency memory model.
  vga_timing_core #(
    .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .RD_LAT(1), .PIX_FMT(1), .CNT_W(12)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fb(fb_a.master),
    .h_sync(hs_a), .v_sync(vs_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a),
    .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a)
  );

  // B: RGB565 constant magenta, active-low syncs, 3-clock latency.
  vga_timing_core #(
    .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(0), .VS_POL(0), .RD_LAT(3), .PIX_FMT(0), .CNT_W(12)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fb(fb_b.master),
    .h_sync(hs_b), .v_sync(vs_b), .de(de_b), .frame_start(fs_b), .line_start(ls_b),
    .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b)
  );

  // C: RGB888, zero-latency memory model.
  vga_timing_core #(
    .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .RD_LAT(0), .PIX_FMT(1), .CNT_W(12)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .fb(fb_c.master),
    .h_sync(hs_c), .v_sync(vs_c), .de(de_c), .frame_start(fs_c), .line_start(ls_c),
    .rgb_r(r_c), .rgb_g(g_c), .rgb_b(b_c)
  );

  // Memory models: pixel value encodes its own address.
  logic [23:0] rd_a = '0;
  always @(posedge clk) rd_a <= {8'h00, fb_a.addr_x[7:0], fb_a.addr_y[7:0]};
  assign fb_a.rgb_data = rd_a;
  assign fb_b.rgb_data = 24'h00F81F;
  assign fb_c.rgb_data = {8'h00, fb_c.addr_x[7:0], fb_c.addr_y[7:0]};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {req, addr_x, addr_y} for raster position k (k<0: idle).
  function automatic logic [31:0] exp_req(input int k);
    int h, v;
    logic act;
    if (k < 0) return 32'h0;
    h   = k % 15;
    v   = (k / 15) % 8;
    act = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    if (!act) return 32'h0;
    return {7'b0, 1'b1, 12'(h - 5), 12'(v - 3)};
  endfunction

  // Expected {hs, vs, de, fs, ls, r, g, b} for raster position k; sel 0 = address pixel, 1 = magenta.
  function automatic logic [31:0] exp_out(input int k, input logic pol, input int sel);
    int h, v;
    logic hs, vs, d, fs, ls;
    logic [23:0] rgb;
    hs = ~pol; vs = ~pol; d = 1'b0; fs = 1'b0; ls = 1'b0; rgb = '0;
    if (k >= 0) begin
      h  = k % 15;
      v  = (k / 15) % 8;
      hs = (h < 3) ? pol : ~pol;
      vs = (v < 2) ? pol : ~pol;
      d  = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
      fs = (h == 0) && (v == 0);
      ls = (h == 0);
      if (d) rgb = (sel == 0) ? {8'h00, 8'(h - 5), 8'(v - 3)} : 24'hFF00FF;
    end
    return {3'b0, hs, vs, d, fs, ls, rgb};
  endfunction

  int hs_hi_a, vs_hi_a, req_cnt_a;
  int first_req [3];
  int first_de  [3];

  // Run n clocks from the first counted clock (c=0), checking every output each cycle.
  task automatic run(input int n);
    hs_hi_a = 0; vs_hi_a = 0; req_cnt_a = 0;
    for (int j = 0; j < 3; j++) begin first_req[j] = -1; first_de[j] = -1; end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check($sformatf("req_a c%0d", c), {7'b0, fb_a.req, fb_a.addr_x, fb_a.addr_y}, exp_req(c - 1));
      check($sformatf("req_b c%0d", c), {7'b0, fb_b.req, fb_b.addr_x, fb_b.addr_y}, exp_req(c - 1));
      check($sformatf("req_c c%0d", c), {7'b0, fb_c.req, fb_c.addr_x, fb_c.addr_y}, exp_req(c - 1));
      check($sformatf("out_a c%0d", c), {3'b0, hs_a, vs_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, exp_out(c - 3, 1'b1, 0));
      check($sformatf("out_b c%0d", c), {3'b0, hs_b, vs_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, exp_out(c - 5, 1'b0, 1));
      check($sformatf("out_c c%0d", c), {3'b0, hs_c, vs_c, de_c, fs_c, ls_c, r_c, g_c, b_c}, exp_out(c - 2, 1'b1, 0));
      if (c >= 3 && c < 123) begin
        hs_hi_a += int'(hs_a);
        vs_hi_a += int'(vs_a);
      end
      if (c >= 1 && c < 121) req_cnt_a += int'(fb_a.req);
      if (fb_a.req && first_req[0] < 0) first_req[0] = c;
      if (fb_b.req && first_req[1] < 0) first_req[1] = c;
      if (fb_c.req && first_req[2] < 0) first_req[2] = c;
      if (de_a && first_de[0] < 0) first_de[0] = c;
      if (de_b && first_de[1] < 0) first_de[1] = c;
      if (de_c && first_de[2] < 0) first_de[2] = c;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_a"}, {7'b0, fb_a.req, fb_a.addr_x, fb_a.addr_y}, exp_req(-1));
    check({tag, "_req_b"}, {7'b0, fb_b.req, fb_b.addr_x, fb_b.addr_y}, exp_req(-1));
    check({tag, "_req_c"}, {7'b0, fb_c.req, fb_c.addr_x, fb_c.addr_y}, exp_req(-1));
    check({tag, "_out_a"}, {3'b0, hs_a, vs_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, exp_out(-1, 1'b1, 0));
    check({tag, "_out_b"}, {3'b0, hs_b, vs_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, exp_out(-1, 1'b0, 1));
    check({tag, "_out_c"}, {3'b0, hs_c, vs_c, de_c, fs_c, ls_c, r_c, g_c, b_c}, exp_out(-1, 1'b1, 0));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_hs_b_level", {31'b0, hs_b}, 32'd1);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("en_low");

    // Two frames plus part of a third; the last cycle sits mid-line in the active area.
    en = 1'b1;
    run(174);
    check("hsync_high_per_frame", hs_hi_a, 24);
    check("vsync_high_per_frame", vs_hi_a, 30);
    check("req_per_frame", req_cnt_a, 32);
    check("first_req_a", first_req[0], 51);
    check("de_offset_lat1", first_de[0] - first_req[0], 2);
    check("de_offset_lat3", first_de[1] - first_req[1], 4);
    check("de_offset_lat0", first_de[2] - first_req[2], 1);

    // Drop en mid-line: req stops next clock, outputs drain within RD_LAT+1.
    check("req_live_before_drop", {31'b0, fb_a.req}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("drop_req_a", {31'b0, fb_a.req}, 32'd0);
    check("drop_req_b", {31'b0, fb_b.req}, 32'd0);
    check("drop_req_c", {31'b0, fb_c.req}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) check("drain_c", {3'b0, hs_c, vs_c, de_c, fs_c, ls_c, r_c, g_c, b_c}, exp_out(-1, 1'b1, 0));
      if (i == 3) check("drain_a", {3'b0, hs_a, vs_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, exp_out(-1, 1'b1, 0));
      if (i == 5) check("drain_b", {3'b0, hs_b, vs_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, exp_out(-1, 1'b0, 1));
    end
    repeat (2) @(negedge clk);
    check_idle("held");

    // Restart from en, then pulse reset while de is active.
    en = 1'b1;
    run(60);
    check("de_live_before_reset", {31'b0, de_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(130);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
